// File: rtl/sqrt_float_pkg.sv
// Shared definitions for the float CORDIC square-root path: FSM encoding,
// IEEE single-precision field widths and special-value encodings.
package sqrt_float_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    PACK  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated fraction given guard and sticky bits.
// Purely combinational; carry flags an all-ones fraction wrapping to zero.
module fp_round_rne #(
  parameter int W = 23
) (
  input  logic [W-1:0] frac,
  input  logic         guard,
  input  logic         sticky,
  output logic [W-1:0] frac_out,
  output logic         carry
);

  logic round_up_s;

  // Increment on guard when above half-way or tied with an odd LSB.
  always_comb begin
    round_up_s = guard & (sticky | frac[0]);
    {carry, frac_out} = {1'b0, frac} + {{W{1'b0}}, round_up_s};
  end

endmodule

// File: rtl/sqrt_float_pack.sv
// Output stage of the CORDIC square root: captures the raw root, normalises it
// one bit per cycle, rounds to nearest-even and packs an IEEE single word.
module sqrt_float_pack
  import sqrt_float_pkg::*;
#(
  parameter int MW    = 32,
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int BIAS  = FP_BIAS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sign,
  input  logic               in_neg,
  input  logic               in_zero,
  input  logic [EXP_W+1:0]   in_exp,
  input  logic [MW-1:0]      in_mant,
  output logic               in_ready,
  output logic [31:0]        result,
  output logic               out_valid,
  output logic               overrun
);

  localparam int EW = EXP_W + 3;
  localparam int GUARD_BIT = MW - 3 - MAN_W;
  localparam logic [MW-1:0] LOW_MASK = (MW'(1) << GUARD_BIT) - MW'(1);
  localparam logic signed [EW-1:0] BIAS_EXT = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  state_t                  state_r;
  logic                    sign_r;
  logic                    neg_r;
  logic                    zero_r;
  logic                    sticky_r;
  logic [MW-1:0]           mant_r;
  logic signed [EW-1:0]    exp_r;
  logic [MAN_W-1:0]        frac_r;

  logic [MAN_W-1:0]        rnd_frac_s;
  logic                    rnd_carry_s;
  logic                    guard_s;
  logic                    sticky_s;
  logic signed [EW-1:0]    biased_s;
  logic [31:0]             pack_s;

  assign in_ready = (state_r == IDLE);

  // Guard and sticky taken with the leading one sitting at bit MW-2.
  always_comb begin
    guard_s  = mant_r[GUARD_BIT];
    sticky_s = (|(mant_r & LOW_MASK)) | sticky_r;
  end

  fp_round_rne #(.W(MAN_W)) u_round (
    .frac     (mant_r[MW-3 -: MAN_W]),
    .guard    (guard_s),
    .sticky   (sticky_s),
    .frac_out (rnd_frac_s),
    .carry    (rnd_carry_s)
  );

  // Final word selection; the root is non-negative except for signed zero.
  always_comb begin
    biased_s = exp_r + BIAS_EXT;
    if (neg_r) begin
      pack_s = QNAN;
    end else if (zero_r) begin
      pack_s = {sign_r, {(EXP_W + MAN_W){1'b0}}};
    end else if (biased_s >= EXP_MAX) begin
      pack_s = PINF;
    end else if (biased_s <= EXP_ZERO) begin
      pack_s = 32'h0000_0000;
    end else begin
      pack_s = {1'b0, biased_s[EXP_W-1:0], frac_r};
    end
  end

  // Capture, normalise, round and pack sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      sign_r    <= 1'b0;
      neg_r     <= 1'b0;
      zero_r    <= 1'b0;
      sticky_r  <= 1'b0;
      mant_r    <= {MW{1'b0}};
      exp_r     <= {EW{1'b0}};
      frac_r    <= {MAN_W{1'b0}};
      result    <= 32'h0000_0000;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= in_valid && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= in_sign;
            neg_r    <= in_neg;
            zero_r   <= in_zero;
            sticky_r <= 1'b0;
            mant_r   <= in_mant;
            exp_r    <= {in_exp[EXP_W+1], in_exp};
            state_r  <= (in_neg || in_zero) ? PACK : NORM;
          end
        end
        NORM: begin
          if (mant_r == {MW{1'b0}}) begin
            zero_r  <= 1'b1;
            state_r <= PACK;
          end else if (mant_r[MW-1]) begin
            mant_r   <= mant_r >> 1;
            sticky_r <= sticky_r | mant_r[0];
            exp_r    <= exp_r + EW'(1);
          end else if (!mant_r[MW-2]) begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - EW'(1);
          end else begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          frac_r <= rnd_frac_s;
          if (rnd_carry_s) begin
            exp_r <= exp_r + EW'(1);
          end
          state_r <= PACK;
        end
        PACK: begin
          result    <= pack_s;
          out_valid <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_float_pack.sv
// Scoreboard bench for sqrt_float_pack: directed vectors push expected words
// and latencies; a negedge monitor pops and compares on every out_valid.
module tb_sqrt_float_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic        in_neg = 1'b0;
  logic        in_zero = 1'b0;
  logic [9:0]  in_exp = 10'd0;
  logic [31:0] in_mant = 32'd0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          cap_q[$];
  int          lat_q[$];

  sqrt_float_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sign   (in_sign),
    .in_neg    (in_neg),
    .in_zero   (in_zero),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] r;
    int c;
    int l;
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious out_valid", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        c = cap_q.pop_front();
        l = lat_q.pop_front();
        check("result", result, r);
        check("latency", 32'(cyc - c), 32'(l));
      end
    end
  end

  // Must be entered just after a negedge; leaves one negedge later.
  task automatic issue(input logic [31:0] m, input logic [9:0] e, input logic s,
                       input logic n, input logic z, input logic [31:0] er,
                       input int lat, input bit expect_out);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("ready timeout", 32'd0, 32'd1);
    in_mant  = m;
    in_exp   = e;
    in_sign  = s;
    in_neg   = n;
    in_zero  = z;
    in_valid = 1'b1;
    if (expect_out) begin
      exp_q.push_back(er);
      cap_q.push_back(cyc);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] m, input logic [9:0] e, input logic s,
                     input logic n, input logic z, input logic [31:0] er, input int lat);
    issue(m, e, s, n, z, er, lat, 1'b1);
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int g;
    repeat (2) @(negedge clk);
    check("reset result", result, 32'h0000_0000);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Normalisation paths
    run(32'h4000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4);
    run(32'h8000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 5);
    run(32'h1000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3E80_0000, 6);
    run(32'h0000_0001, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3080_0000, 34);
    // Rounding
    run(32'h4000_0040, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4);
    run(32'h4000_00C0, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 4);
    run(32'h7FFF_FFFF, 10'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 4);
    run(32'h8000_0081, 10'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0001, 5);
    // Specials
    run(32'h4000_0000, 10'd0, 1'b0, 1'b1, 1'b0, 32'h7FC0_0000, 2);
    run(32'h4000_0000, 10'd0, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 2);
    run(32'h0000_0000, 10'd0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 2);
    run(32'h0000_0000, 10'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2);
    run(32'h0000_0000, 10'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3);
    // Exponent range boundaries
    run(32'h4000_0000, 10'd200, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 4);
    run(32'h4000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 4);
    run(32'h4000_0000, 10'd128, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 4);
    run(32'h4000_0000, -10'sd126, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 4);
    run(32'h4000_0000, -10'sd127, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4);
    run(32'h4000_0000, -10'sd140, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4);

    // Back-to-back: new operand accepted in the out_valid cycle
    issue(32'h4000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4, 1'b1);
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("ready with out_valid", {31'd0, in_ready}, 32'd1);
    issue(32'h8000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 5, 1'b1);
    drain();

    // Overrun: a second operand during NORM is dropped
    issue(32'h1000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3E80_0000, 6, 1'b1);
    check("busy in_ready", {31'd0, in_ready}, 32'd0);
    in_mant  = 32'h7FFF_FFFF;
    in_neg   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_neg   = 1'b0;
    check("overrun pulse", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    check("overrun single", {31'd0, overrun}, 32'd0);
    drain();

    // Reset mid-operation aborts with no output
    issue(32'h1000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("abort result", result, 32'h0000_0000);
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort result held", result, 32'h0000_0000);
    run(32'h4000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
